// File: rtl/grf_trace_dumper_pkg.sv
// Shared definitions for the GRF trace dumper: record kinds, FSM encoding,
// register-file geometry and a small index helper.
package grf_trace_dumper_pkg;

  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned REG_W    = 5;
  localparam int unsigned DATA_W   = 32;

  localparam logic KIND_TRACE = 1'b0;
  localparam logic KIND_DUMP  = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    SCAN  = 2'd2
  } state_e;

  // True when idx is the last architectural register.
  function automatic logic is_last_reg(input logic [REG_W-1:0] idx);
    return idx == REG_W'(NUM_REGS - 1);
  endfunction

endpackage

// File: rtl/grf_trace_dumper_trace_fifo.sv
// Synchronous FIFO buffering snooped register writes.
// Ports: clk/rst_n (sync active-low), push_i/wdata_i write side,
// pop_i read side, head_o current head entry, full_o/empty_o status.
// A push into a full FIFO is accepted only when a pop happens the same cycle.
module grf_trace_dumper_trace_fifo #(
  parameter int unsigned WIDTH = 69,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam int unsigned PW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_q;
  logic [PW-1:0]    rd_q;
  logic             do_push;
  logic             do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign head_o  = mem_q[rd_q[AW-1:0]];

  // Pointer registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + PW'(1);
      if (do_pop)  rd_q <= rd_q + PW'(1);
    end
  end

  // Storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/grf_trace_dumper.sv
// GRF trace dumper: snoops register-file writes into a trace FIFO and, on
// DumpReq, walks all 32 registers through a read port. Both record kinds
// leave through one registered valid/ready output stage.
// Ports: Clk/Reset (sync active-low); WE/RW/WD/WPC snooped write port;
// DumpReq dump trigger; RA/busA GRF read port; out_* record stream;
// busy (dump in progress); overflow (sticky dropped-write flag).
module grf_trace_dumper
  import grf_trace_dumper_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned PC_W       = 32
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              WE,
  input  logic [4:0]        RW,
  input  logic [31:0]       WD,
  input  logic [PC_W-1:0]   WPC,
  input  logic              DumpReq,
  output logic [4:0]        RA,
  input  logic [31:0]       busA,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_kind,
  output logic [PC_W-1:0]   out_pc,
  output logic [4:0]        out_reg,
  output logic [31:0]       out_data,
  output logic              busy,
  output logic              overflow
);

  localparam int unsigned REC_W = PC_W + REG_W + DATA_W;

  state_e            state_q, state_d;
  logic [REG_W-1:0]  idx_q, idx_d;
  logic              valid_q, valid_d;
  logic              kind_q, kind_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [REG_W-1:0]  reg_q, reg_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              busy_q, busy_d;
  logic              ovf_q, ovf_d;

  logic              capture;
  logic              load_en;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [REC_W-1:0]  fifo_head;

  // Writes to r0 carry no architectural state and are never traced.
  assign capture = WE && (RW != '0);
  assign load_en = !valid_q || out_ready;

  grf_trace_dumper_trace_fifo #(
    .WIDTH (REC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (Clk),
    .rst_n   (Reset),
    .push_i  (capture),
    .wdata_i ({WPC, RW, WD}),
    .pop_i   (fifo_pop),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Next-state, output-stage load and FIFO pop.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    valid_d  = valid_q;
    kind_d   = kind_q;
    pc_d     = pc_q;
    reg_d    = reg_q;
    data_d   = data_q;
    ovf_d    = ovf_q;
    busy_d   = busy_q;
    fifo_pop = 1'b0;

    unique case (state_q)
      IDLE, DRAIN: begin
        if (load_en) begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            valid_d  = 1'b1;
            kind_d   = KIND_TRACE;
            {pc_d, reg_d, data_d} = fifo_head;
          end else begin
            valid_d = 1'b0;
          end
        end
        if (state_q == IDLE) begin
          if (DumpReq) state_d = DRAIN;
        end else if (fifo_empty && load_en) begin
          // All older trace records are out; the scan starts next cycle.
          state_d = SCAN;
          idx_d   = '0;
        end
      end
      SCAN: begin
        // FIFO is frozen here; new writes queue up behind the dump.
        if (load_en) begin
          valid_d = 1'b1;
          kind_d  = KIND_DUMP;
          pc_d    = '0;
          reg_d   = idx_q;
          data_d  = busA;
          if (is_last_reg(idx_q)) begin
            state_d = IDLE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + REG_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (capture && fifo_full && !fifo_pop) ovf_d = 1'b1;
    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      valid_q <= 1'b0;
      kind_q  <= KIND_TRACE;
      pc_q    <= '0;
      reg_q   <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      kind_q  <= kind_d;
      pc_q    <= pc_d;
      reg_q   <= reg_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
    end
  end

  // idx_q is held at zero outside SCAN, so it drives the read port directly.
  assign RA        = idx_q;
  assign out_valid = valid_q;
  assign out_kind  = kind_q;
  assign out_pc    = pc_q;
  assign out_reg   = reg_q;
  assign out_data  = data_q;
  assign busy      = busy_q;
  assign overflow  = ovf_q;

endmodule
